// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sequences an external, reset-less synchronous FIFO as a
// programmable N-sample delay line. The FIFO's stale contents are flushed
// after reset. Growth of the delay inserts zero samples. Shrinking the delay
// discards the oldest entries in idle cycles.
module delay_line_ctrl #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 10,
   localparam int unsigned DW    = $clog2(DEPTH),
   localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [DW-1:0]    i_delay_samples,
   input  logic [WIDTH-1:0] i_sample_in,
   input  logic             i_sample_in_valid,
   output logic [WIDTH-1:0] o_sample_out,
   output logic             o_sample_out_valid,
   output logic             o_ready,
   output logic             o_dropped,
   output logic [LW-1:0]    o_level,
   output logic [WIDTH-1:0] o_fifo_data_in,
   output logic             o_fifo_wr_en,
   output logic             o_fifo_rd_en,
   input  logic [WIDTH-1:0] i_fifo_data_out,
   input  logic             i_fifo_empty,
   input  logic             i_fifo_full
);

   typedef enum logic [1:0] {StFlush, StFill, StRun, StShrink} state_e;

   state_e           r_state;
   logic [LW-1:0]    r_level;
   logic [DW-1:0]    r_target;
   logic             r_ready;
   logic             r_dropped;
   logic             r_p1_valid;   // read-type tag, stage 1: an output is owed next cycle
   logic             r_p1_data;    // owed output comes from FIFO data (else it is a zero)
   logic [WIDTH-1:0] r_sample_out;
   logic             r_sample_out_valid;

   logic [DW-1:0]    w_target_nxt;
   logic [LW-1:0]    w_level_nxt;
   state_e           w_state_nxt;
   logic             w_active;
   logic             w_wr_en;
   logic             w_rd_data;
   logic             w_rd_discard;
   logic             w_rd_flush;
   logic             w_unused_full;

   // The full flag is never expected to assert: level stays below DEPTH.
   assign w_unused_full = i_fifo_full;

   assign w_active     = !i_rst && (r_state != StFlush);
   assign w_wr_en      = w_active && i_sample_in_valid;
   assign w_rd_data    = w_wr_en && ((r_state == StRun) || (r_state == StShrink));
   // A strobe takes priority over a shrink discard in the same cycle.
   assign w_rd_discard = w_active && !i_sample_in_valid && (r_state == StShrink);
   assign w_rd_flush   = !i_rst && (r_state == StFlush) && !i_fifo_empty;

   assign o_fifo_data_in     = i_sample_in;
   assign o_fifo_wr_en       = w_wr_en;
   assign o_fifo_rd_en       = w_rd_data || w_rd_discard || w_rd_flush;
   assign o_sample_out       = r_sample_out;
   assign o_sample_out_valid = r_sample_out_valid;
   assign o_ready            = r_ready;
   assign o_dropped          = r_dropped;
   assign o_level            = r_level;

   // Clamp the requested delay into the legal range 1..DEPTH-1.
   always_comb begin
      w_target_nxt = i_delay_samples;
      if (i_delay_samples == '0) begin
         w_target_nxt = DW'(1);
      end else if (32'(i_delay_samples) > DEPTH - 1) begin
         w_target_nxt = DW'(DEPTH - 1);
      end
   end

   // Next level from this cycle's FIFO traffic; next state from next level vs next target,
   // so the state always reflects the level/target relation seen in the following cycle.
   always_comb begin
      w_level_nxt = r_level;
      if (w_wr_en && (r_state == StFill)) begin
         w_level_nxt = r_level + LW'(1);
      end else if (w_rd_discard) begin
         w_level_nxt = r_level - LW'(1);
      end
      if (32'(w_level_nxt) < 32'(w_target_nxt)) begin
         w_state_nxt = StFill;
      end else if (32'(w_level_nxt) == 32'(w_target_nxt)) begin
         w_state_nxt = StRun;
      end else begin
         w_state_nxt = StShrink;
      end
   end

   // Controller FSM with registered outputs and the two-stage output pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state            <= StFlush;
         r_level            <= '0;
         r_target           <= DW'(1);
         r_ready            <= 1'b0;
         r_dropped          <= 1'b0;
         r_p1_valid         <= 1'b0;
         r_p1_data          <= 1'b0;
         r_sample_out       <= '0;
         r_sample_out_valid <= 1'b0;
      end else begin
         r_target           <= w_target_nxt;
         r_p1_valid         <= w_wr_en;
         r_p1_data          <= w_rd_data;
         r_sample_out_valid <= r_p1_valid;
         if (r_p1_valid) begin
            r_sample_out <= r_p1_data ? i_fifo_data_out : '0;
         end
         unique case (r_state)
            StFlush: begin
               if (i_sample_in_valid) begin
                  r_dropped <= 1'b1;
               end
               if (i_fifo_empty) begin
                  r_state <= StFill;
                  r_level <= '0;
                  r_ready <= 1'b1;
               end
            end
            StFill, StRun, StShrink: begin
               r_level <= w_level_nxt;
               r_state <= w_state_nxt;
            end
            default: r_state <= StFlush;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: a behavioural FIFO environment, a queue-based delay-line
// reference model feeding a scoreboard, and a monitor that checks value and timing.
module tb_delay_line_ctrl;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 10;
   localparam int unsigned DW    = 4;
   localparam int unsigned LW    = 4;

   logic             clk;
   logic             i_rst;
   logic [DW-1:0]    i_delay_samples;
   logic [WIDTH-1:0] i_sample_in;
   logic             i_sample_in_valid;
   logic [WIDTH-1:0] o_sample_out;
   logic             o_sample_out_valid;
   logic             o_ready;
   logic             o_dropped;
   logic [LW-1:0]    o_level;
   logic [WIDTH-1:0] o_fifo_data_in;
   logic             o_fifo_wr_en;
   logic             o_fifo_rd_en;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_empty;
   logic             fifo_full;

   typedef struct {
      int               due;
      logic [WIDTH-1:0] val;
   } exp_t;

   exp_t             sb[$];
   exp_t             mon_e;
   logic [WIDTH-1:0] m_q[$];   // reference: samples currently held in the delay line
   logic [WIDTH-1:0] f_q[$];   // environment FIFO storage
   bit               m_dropped;
   int               flush_end;
   int               cyc;
   int               n_checks;
   int               n_fail;
   logic [DW-1:0]    prev_ds;
   logic [DW-1:0]    ds_r;
   logic [WIDTH-1:0] seq;

   delay_line_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk             (clk),
      .i_rst             (i_rst),
      .i_delay_samples   (i_delay_samples),
      .i_sample_in       (i_sample_in),
      .i_sample_in_valid (i_sample_in_valid),
      .o_sample_out      (o_sample_out),
      .o_sample_out_valid(o_sample_out_valid),
      .o_ready           (o_ready),
      .o_dropped         (o_dropped),
      .o_level           (o_level),
      .o_fifo_data_in    (o_fifo_data_in),
      .o_fifo_wr_en      (o_fifo_wr_en),
      .o_fifo_rd_en      (o_fifo_rd_en),
      .i_fifo_data_out   (fifo_dout),
      .i_fifo_empty      (fifo_empty),
      .i_fifo_full       (fifo_full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Environment FIFO: no reset, registered read data, full/empty from occupancy.
   always @(posedge clk) begin
      int sz0;
      sz0 = f_q.size();
      if (o_fifo_wr_en === 1'b1) begin
         check("write_not_full", 32'(sz0 >= int'(DEPTH)), 32'd0);
      end
      if (o_fifo_rd_en === 1'b1 && sz0 > 0) fifo_dout <= f_q.pop_front();
      if (o_fifo_wr_en === 1'b1 && sz0 < int'(DEPTH)) f_q.push_back(o_fifo_data_in);
      fifo_empty <= (f_q.size() == 0);
      fifo_full  <= (f_q.size() >= int'(DEPTH));
   end

   // Monitor: every presented output must match the oldest outstanding expectation.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL missing_out: no output, expected %0d due cycle %0d", sb[0].val, sb[0].due);
         void'(sb.pop_front());
      end
      if (o_sample_out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got %0d, expected no output (cycle %0d)",
                     o_sample_out, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("out_value", 32'(o_sample_out), 32'(mon_e.val));
            check("out_cycle", 32'(cyc), 32'(mon_e.due));
         end
      end
   end

   function automatic int clamp(input logic [DW-1:0] ds);
      if (ds == 0) return 1;
      if (int'(ds) > int'(DEPTH) - 1) return int'(DEPTH) - 1;
      return int'(ds);
   endfunction

   // Delay-line rule: a strobe yields the oldest held sample once N are held, else zero.
   task automatic model_step(input bit s, input logic [WIDTH-1:0] x);
      int   t;
      exp_t e;
      t = clamp(prev_ds);
      if (cyc <= flush_end) begin
         if (s) m_dropped = 1'b1;
      end else if (s) begin
         e.due = cyc + 2;
         if (m_q.size() < t) e.val = '0;
         else e.val = m_q.pop_front();
         m_q.push_back(x);
         sb.push_back(e);
      end else if (m_q.size() > t) begin
         void'(m_q.pop_front());
      end
   endtask

   // One clock cycle: check status outputs, apply inputs, advance the model.
   task automatic cycle(input bit s, input logic [WIDTH-1:0] x, input logic [DW-1:0] ds);
      check("level", 32'(o_level), 32'(m_q.size()));
      check("ready", 32'(o_ready), 32'(cyc > flush_end));
      check("dropped", 32'(o_dropped), 32'(m_dropped));
      i_sample_in_valid = s;
      i_sample_in       = x;
      i_delay_samples   = ds;
      model_step(s, x);
      prev_ds = ds;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int hold);
      i_sample_in_valid = 1'b0;
      i_rst = 1'b1;
      #1;
      check("rst_out", 32'(o_sample_out), 32'd0);
      check("rst_out_valid", 32'(o_sample_out_valid), 32'd0);
      check("rst_ready", 32'(o_ready), 32'd0);
      check("rst_dropped", 32'(o_dropped), 32'd0);
      check("rst_level", 32'(o_level), 32'd0);
      sb.delete();
      m_q.delete();
      m_dropped = 1'b0;
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      i_rst = 1'b0;
      flush_end = cyc + f_q.size();
   endtask

   task automatic burst(input int n, input int gap, input logic [DW-1:0] ds, input bit rnd);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, rnd ? WIDTH'($urandom) : seq, ds);
         seq++;
         repeat (gap) cycle(1'b0, '0, ds);
      end
   endtask

   task automatic idle(input int n, input logic [DW-1:0] ds);
      repeat (n) cycle(1'b0, '0, ds);
   endtask

   initial begin
      cyc = 0;
      n_checks = 0;
      n_fail = 0;
      m_dropped = 1'b0;
      flush_end = 0;
      i_rst = 1'b1;
      i_sample_in_valid = 1'b0;
      i_sample_in = '0;
      i_delay_samples = 4'd3;
      prev_ds = 4'd3;
      seq = 8'd1;
      fifo_dout = '0;
      f_q = {8'h11, 8'h22, 8'h33, 8'h44};   // stale power-up contents
      fifo_empty = 1'b0;
      fifo_full = 1'b0;
      @(posedge clk);
      #1;
      do_reset(2);
      while (cyc <= flush_end) cycle(1'b0, '0, 4'd3);
      idle(2, 4'd3);
      // Delay 3, a strobe every 4 cycles.
      burst(8, 3, 4'd3, 1'b0);
      // Delay 9, back-to-back strobes.
      seq = 8'd1;
      idle(2, 4'd9);
      burst(20, 0, 4'd9, 1'b0);
      // Shrink 5 -> 2 with idle gaps.
      burst(10, 0, 4'd5, 1'b1);
      burst(8, 2, 4'd2, 1'b1);
      // Grow 2 -> 6.
      burst(10, 1, 4'd2, 1'b1);
      burst(12, 0, 4'd6, 1'b1);
      // Reset at level 7, strobes arrive during the flush.
      burst(12, 0, 4'd7, 1'b1);
      do_reset(1);
      burst(3, 1, 4'd7, 1'b1);
      while (cyc <= flush_end) cycle(1'b0, '0, 4'd7);
      burst(12, 0, 4'd7, 1'b1);
      // Clamping at both ends.
      burst(10, 1, 4'd0, 1'b1);
      burst(16, 0, 4'd15, 1'b1);
      // Randomised traffic, delay changes and occasional resets.
      ds_r = 4'd4;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) ds_r = DW'($urandom_range(0, 15));
         if ($urandom_range(0, 299) == 0) do_reset(1 + int'($urandom_range(0, 2)));
         cycle($urandom_range(0, 9) < 6, WIDTH'($urandom), ds_r);
      end
      idle(5, ds_r);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
